// File: rtl/tusca_pkg.sv
// Shared types for the TUSCA control unit: state encoding and command bundle.
package tusca_pkg;

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        CONFIG        = 4'h1,
        ESPERA_CONFIG = 4'h2,
        ERRO_CONFIG   = 4'h3,
        ZERA          = 4'h4,
        MEDE          = 4'h5,
        ESPERA_MEDIDA = 4'h6,
        GIRA          = 4'h7,
        ESPERA_DELAY  = 4'h8,
        FALHA         = 4'hF
    } estado_t;

    localparam logic [3:0] DB_FALHA = 4'hF;

    typedef struct packed {
        logic receber_config;
        logic medir_dht11;
        logic zera_delay;
        logic conta_delay;
        logic gira;
        logic falha;
    } cmd_t;

    // Moore output decode: commands depend only on the state.
    function automatic cmd_t decode_cmd(estado_t e);
        cmd_t c;
        c = '0;
        case (e)
            CONFIG:       c.receber_config = 1'b1;
            ZERA:         c.zera_delay     = 1'b1;
            MEDE:         c.medir_dht11    = 1'b1;
            GIRA:         c.gira           = 1'b1;
            ESPERA_DELAY: c.conta_delay    = 1'b1;
            FALHA:        c.falha          = 1'b1;
            default:      c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tusca_uc_if.sv
// Command/status bundle between the TUSCA control unit and its datapath.
interface tusca_uc_if;

    logic       iniciar;
    logic       reconfigurar;
    logic       pronto_config;
    logic       erro_config;
    logic       pronto_medida;
    logic       fim_delay;
    logic       receber_config;
    logic       medir_dht11;
    logic       zera_delay;
    logic       conta_delay;
    logic       gira;
    logic       falha;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, reconfigurar, pronto_config, erro_config, pronto_medida, fim_delay,
        output receber_config, medir_dht11, zera_delay, conta_delay, gira, falha, db_estado
    );

    modport slave (
        output iniciar, reconfigurar, pronto_config, erro_config, pronto_medida, fim_delay,
        input  receber_config, medir_dht11, zera_delay, conta_delay, gira, falha, db_estado
    );

endinterface

// File: rtl/tusca_watchdog.sv
// Wait-state watchdog: counts enabled cycles after a clear, flags the TIMEOUT-th one.
module tusca_watchdog #(
    parameter int unsigned TIMEOUT = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expira_o
);

    localparam int unsigned     WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] LIMITE = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] cnt_q, cnt_d;
    logic            expira_q, expira_d;

    // Saturates at LIMITE so the counter never wraps while the FSM leaves the state.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LIMITE)) begin
            cnt_d = cnt_q + WD_W'(1);
        end
        expira_d = (cnt_d == LIMITE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            expira_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expira_q <= expira_d;
        end
    end

    assign expira_o = expira_q;

endmodule

// File: rtl/tusca_uc.sv
// TUSCA control unit: config load, periodic DHT11 measurement, servo step, delay; bounded retries.
// Optional macro TUSCA_UC_WATCHDOG_EN adds the wait-state watchdog and timeout transitions.
module tusca_uc
    import tusca_pkg::*;
#(
    parameter int unsigned TIMEOUT          = 50_000_000,
    parameter int unsigned MAX_TENTATIVAS   = 3,
    parameter int unsigned MEDIDAS_POR_GIRO = 4
) (
    input  logic       clock,
    input  logic       reset,
    tusca_uc_if.master bus
);

    localparam int unsigned       TENT_W   = $clog2(MAX_TENTATIVAS + 1);
    localparam int unsigned       MED_W    = $clog2(MEDIDAS_POR_GIRO + 1);
    localparam logic [TENT_W-1:0] TENT_MAX = TENT_W'(MAX_TENTATIVAS);
    localparam logic [MED_W-1:0]  MED_MAX  = MED_W'(MEDIDAS_POR_GIRO);

    estado_t           state_q, state_d;
    logic [TENT_W-1:0] tent_q, tent_d, tent_inc;
    logic [MED_W-1:0]  med_q, med_d, med_inc;
    cmd_t              cmd_q;
    logic              expira;

    assign tent_inc = tent_q + TENT_W'(1);
    assign med_inc  = med_q + MED_W'(1);

`ifdef TUSCA_UC_WATCHDOG_EN
    logic wd_clr;
    logic wd_en;

    assign wd_clr = (state_q == CONFIG) || (state_q == MEDE);
    assign wd_en  = (state_q == ESPERA_CONFIG) || (state_q == ESPERA_MEDIDA);

    tusca_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clock),
        .rst      (reset),
        .clear_i  (wd_clr),
        .enable_i (wd_en),
        .expira_o (expira)
    );
`else
    logic unused_timeout;

    assign unused_timeout = ^32'(TIMEOUT);
    assign expira         = 1'b0;
`endif

    // Next-state and counter update; done pulses take priority over timeouts.
    always_comb begin
        state_d = state_q;
        tent_d  = tent_q;
        med_d   = med_q;
        case (state_q)
            INICIAL: begin
                if (bus.iniciar) begin
                    state_d = CONFIG;
                    tent_d  = '0;
                    med_d   = '0;
                end
            end
            CONFIG: state_d = ESPERA_CONFIG;
            ESPERA_CONFIG: begin
                if (bus.pronto_config) begin
                    if (bus.erro_config) begin
                        state_d = ERRO_CONFIG;
                    end else begin
                        state_d = ZERA;
                        tent_d  = '0;
                    end
                end else if (expira) begin
                    state_d = ERRO_CONFIG;
                end
            end
            ERRO_CONFIG: begin
                if (tent_inc == TENT_MAX) begin
                    state_d = FALHA;
                    tent_d  = '0;
                end else begin
                    state_d = CONFIG;
                    tent_d  = tent_inc;
                end
            end
            ZERA: state_d = MEDE;
            MEDE: state_d = ESPERA_MEDIDA;
            ESPERA_MEDIDA: begin
                if (bus.pronto_medida) begin
                    tent_d = '0;
                    if (med_inc == MED_MAX) begin
                        state_d = GIRA;
                        med_d   = '0;
                    end else begin
                        state_d = ESPERA_DELAY;
                        med_d   = med_inc;
                    end
                end else if (expira) begin
                    if (tent_inc == TENT_MAX) begin
                        state_d = FALHA;
                        tent_d  = '0;
                    end else begin
                        state_d = ZERA;
                        tent_d  = tent_inc;
                    end
                end
            end
            GIRA: state_d = ESPERA_DELAY;
            ESPERA_DELAY: begin
                if (bus.reconfigurar) begin
                    state_d = CONFIG;
                    tent_d  = '0;
                    med_d   = '0;
                end else if (bus.fim_delay) begin
                    state_d = ZERA;
                end
            end
            FALHA: begin
                if (bus.iniciar) begin
                    state_d = CONFIG;
                    tent_d  = '0;
                    med_d   = '0;
                end
            end
            default: state_d = INICIAL;
        endcase
    end

    // Commands are registered from the next state so they track the state register exactly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= INICIAL;
            tent_q  <= '0;
            med_q   <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            tent_q  <= tent_d;
            med_q   <= med_d;
            cmd_q   <= decode_cmd(state_d);
        end
    end

    assign bus.receber_config = cmd_q.receber_config;
    assign bus.medir_dht11    = cmd_q.medir_dht11;
    assign bus.zera_delay     = cmd_q.zera_delay;
    assign bus.conta_delay    = cmd_q.conta_delay;
    assign bus.gira           = cmd_q.gira;
    assign bus.falha          = cmd_q.falha;
    assign bus.db_estado      = state_q;

endmodule

// File: doc/tusca_uc.md
Name: tusca_uc

Overview:
Control unit (FSM) directly upstream of the TUSCA datapath: sequences configuration load, periodic DHT11 measurement, servo rotation and inter-measurement delay.
- Drives the datapath command inputs: receber_config, medir_dht11, zera_delay, conta_delay, gira.
- Consumes the datapath status outputs: pronto_config, erro_config, pronto_medida, fim_delay.
- Adds bounded retries and a watchdog; on exhausted retries it parks in FALHA.

Parameters:
TIMEOUT, 50_000_000, watchdog limit in clock cycles while waiting for pronto_config/pronto_medida
MAX_TENTATIVAS, 3, consecutive failed attempts (config or measurement) before FALHA; must be >= 1
MEDIDAS_POR_GIRO, 4, successful measurements between gira pulses; must be >= 1

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
iniciar  in  1  start request (level, sampled on clock)
reconfigurar  in  1  request to reload configuration (honoured only in ESPERA_DELAY)
pronto_config  in  1  config manager done pulse
erro_config  in  1  config error, qualified by pronto_config
pronto_medida  in  1  DHT11 measurement done pulse
fim_delay  in  1  delay counter terminal count
receber_config  out  1  start config reception
medir_dht11  out  1  start measurement
zera_delay  out  1  synchronous clear of delay counter
conta_delay  out  1  delay counter enable
gira  out  1  servo step command
falha  out  1  unrecoverable fault indicator
db_estado  out  4  current state encoding

Behaviour:
- Moore FSM. All outputs decode from the state register only; no input-to-output combinational path.
- Reset (async): state=INICIAL, all counters 0, all outputs 0, db_estado=0.
- Encoding: INICIAL=0, CONFIG=1, ESPERA_CONFIG=2, ERRO_CONFIG=3, ZERA=4, MEDE=5, ESPERA_MEDIDA=6, GIRA=7, ESPERA_DELAY=8, FALHA=F.
- INICIAL: iniciar=1 -> CONFIG; clear tentativas and contagem of medidas.
  - Latency: iniciar high at edge k -> receber_config high for exactly cycle k+1.
- CONFIG: receber_config=1 for 1 cycle; clear watchdog -> ESPERA_CONFIG.
- ESPERA_CONFIG: watchdog increments each cycle.
  - pronto_config & !erro_config -> ZERA; tentativas=0.
  - pronto_config & erro_config -> ERRO_CONFIG.
  - watchdog==TIMEOUT-1 without pronto_config -> ERRO_CONFIG.
  - pronto_config wins over a same-cycle timeout.
- ERRO_CONFIG: tentativas+1.
  - New value == MAX_TENTATIVAS -> FALHA.
  - Otherwise -> CONFIG.
- ZERA: zera_delay=1 for 1 cycle -> MEDE.
- MEDE: medir_dht11=1 for 1 cycle; clear watchdog -> ESPERA_MEDIDA.
- ESPERA_MEDIDA:
  - pronto_medida: tentativas=0; medidas+1. If the new value == MEDIDAS_POR_GIRO, clear medidas and go to GIRA; else go to ESPERA_DELAY.
  - Timeout: tentativas+1. If the new value == MAX_TENTATIVAS -> FALHA; else -> ZERA (retry).
  - pronto_medida beats a same-cycle timeout.
- GIRA: gira=1 for 1 cycle -> ESPERA_DELAY.
- ESPERA_DELAY: conta_delay=1.
  - reconfigurar=1 -> CONFIG, with tentativas and medidas cleared.
  - Else fim_delay=1 -> ZERA.
  - reconfigurar beats a same-cycle fim_delay.
- FALHA: falha=1, all command outputs 0; iniciar=1 -> CONFIG with counters cleared.
- Status inputs arriving in states that do not wait for them are ignored.
- Widths:
  - watchdog: $clog2(TIMEOUT)
  - tentativas: $clog2(MAX_TENTATIVAS+1)
  - medidas: $clog2(MEDIDAS_POR_GIRO+1)
  - No counter ever wraps: each is cleared on the transition that consumes its limit.
- Reset mid-operation: immediate return to INICIAL, outputs 0 asynchronously. The datapath delay counter is cleared by the shared reset.

Optional Feature:
TUSCA_UC_WATCHDOG_EN
- Defined: watchdog counter and timeout transitions exist as specified above.
- Undefined: no watchdog register. ESPERA_CONFIG and ESPERA_MEDIDA wait indefinitely, and FALHA is reachable only via repeated erro_config. TIMEOUT is unused; the port list is unchanged.

Decomposition:
- Package tusca_pkg: state enum type estado_t (4-bit) with the encodings above, plus the db_estado constant for FALHA.
- Sub-module tusca_watchdog: clear/enable inputs, expira output. Compiled only under TUSCA_UC_WATCHDOG_EN.

Test Plan:
1. Bench parameters: TIMEOUT=20, MAX_TENTATIVAS=3, MEDIDAS_POR_GIRO=2; watchdog on unless stated.
2. Reset, iniciar pulse, pronto_config (erro=0) 5 cycles later, then pronto_medida -> receber_config 1 cycle; zera_delay then medir_dht11 each 1 cycle; db_estado=8 with conta_delay=1.
3. Two measurements with fim_delay between them -> gira high exactly 1 cycle after the 2nd pronto_medida (db_estado=7); no gira after the 1st.
4. pronto_config with erro_config=1 three times -> receber_config pulses 3 times, then falha=1, db_estado=F; iniciar -> back to CONFIG.
5. No pronto_medida for 20 cycles, twice, then pronto_medida -> two ZERA/MEDE retries, no falha, tentativas cleared.
6. In ESPERA_DELAY, reconfigurar and fim_delay together -> next state CONFIG (receber_config=1), not ZERA. Assert reset in ESPERA_MEDIDA -> outputs 0 before the next edge.
